// File: rtl/vga_dac_pkg.sv
// Shared timing defaults, source-mode encoding and small helpers for the VGA DAC sequencer.
// Defaults describe 640x480@60 at a 25.175 MHz pixel clock.
package vga_dac_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam bit DEF_SYNC_POL  = 1'b0;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_EXT      = 2'd2,
    MODE_RAMP     = 2'd3
  } mode_e;

  function automatic logic in_window(input logic [9:0] x, input int lo, input int hi);
    return (x >= 10'(lo)) && (x < 10'(hi));
  endfunction

  // Colour-bar index as a comparator chain so no divider is built.
  function automatic logic [2:0] bar_index(input logic [9:0] x, input int bar_w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(i * bar_w)) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_dac_sequencer_if.sv
// Control inputs and video outputs of the DAC sequencer; master drives controls, slave drives video.
interface vga_dac_sequencer_if;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] ext_r, ext_g, ext_b;
  logic       hsync, vsync, de;
  logic [7:0] dac_r, dac_g, dac_b;
  logic [9:0] hpos, vpos;
  logic [7:0] frame;
  logic [1:0] mode_active;

  modport master (
    output enable, mode, ext_r, ext_g, ext_b,
    input  hsync, vsync, de, dac_r, dac_g, dac_b, hpos, vpos, frame, mode_active
  );

  modport slave (
    input  enable, mode, ext_r, ext_g, ext_b,
    output hsync, vsync, de, dac_r, dac_g, dac_b, hpos, vpos, frame, mode_active
  );
endinterface

// File: rtl/vga_timing_counter.sv
// Raster h/v counters with combinational sync/de windows and a frame-end strobe.
// Strobes reflect the current count (zero latency); enable low freezes the count.
module vga_timing_counter
  import vga_dac_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       frame_end,
  output logic       hsync_on,
  output logic       vsync_on,
  output logic       de_on
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic line_end;
  logic last_line;

  assign line_end  = (h == 10'(H_TOTAL - 1));
  assign last_line = (v == 10'(V_TOTAL - 1));
  assign frame_end = line_end && last_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (enable) begin
      if (line_end) begin
        h <= 10'd0;
        v <= last_line ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign hsync_on = in_window(h, H_VISIBLE + H_FRONT, H_VISIBLE + H_FRONT + H_SYNC);
  assign vsync_on = in_window(v, V_VISIBLE + V_FRONT, V_VISIBLE + V_FRONT + V_SYNC);
  assign de_on    = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));
endmodule

// File: rtl/vga_dac_sequencer.sv
// Drives the three video DACs and VGA syncs from one of four pixel sources.
// One register stage from counter to outputs; enable low holds every output and all state.
module vga_dac_sequencer
  import vga_dac_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = DEF_SYNC_POL
) (
  input logic               clk,
  input logic               rst,
  vga_dac_sequencer_if.slave bus
);
  logic [9:0] h, v;
  logic       frame_end, hsync_on, vsync_on, de_on;

  vga_timing_counter #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk(clk), .rst(rst), .enable(bus.enable),
    .h(h), .v(v), .frame_end(frame_end),
    .hsync_on(hsync_on), .vsync_on(vsync_on), .de_on(de_on)
  );

  logic [7:0] frame_q;
  mode_e      mode_q;
  logic       hsync_q, vsync_q, de_q;
  logic [7:0] r_q, g_q, b_q;
  logic [9:0] hpos_q, vpos_q;
  logic [7:0] r_nxt, g_nxt, b_nxt;
  logic [2:0] bar;

  always_comb begin
    r_nxt = 8'd0;
    g_nxt = 8'd0;
    b_nxt = 8'd0;
    bar   = bar_index(h, H_VISIBLE / 8);
    if (de_on) begin
      case (mode_q)
        MODE_GRADIENT: begin r_nxt = h[7:0];      g_nxt = v[7:0];      b_nxt = frame_q;     end
        MODE_BARS:     begin r_nxt = {8{bar[2]}}; g_nxt = {8{bar[1]}}; b_nxt = {8{bar[0]}}; end
        MODE_EXT:      begin r_nxt = bus.ext_r;   g_nxt = bus.ext_g;   b_nxt = bus.ext_b;   end
        MODE_RAMP:     begin r_nxt = v[8:1];      g_nxt = v[8:1];      b_nxt = v[8:1];      end
        default:       begin r_nxt = 8'd0;        g_nxt = 8'd0;        b_nxt = 8'd0;        end
      endcase
    end
  end

  // Mode is latched only on the frame-wrap cycle so a frame never mixes sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= 8'd0;
      mode_q  <= MODE_GRADIENT;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
      hpos_q  <= 10'd0;
      vpos_q  <= 10'd0;
    end else if (bus.enable) begin
      if (frame_end) begin
        frame_q <= frame_q + 8'd1;
        mode_q  <= mode_e'(bus.mode);
      end
      hsync_q <= hsync_on ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vsync_on ? SYNC_POL : ~SYNC_POL;
      de_q    <= de_on;
      r_q     <= r_nxt;
      g_q     <= g_nxt;
      b_q     <= b_nxt;
      hpos_q  <= h;
      vpos_q  <= v;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.dac_r       = r_q;
  assign bus.dac_g       = g_q;
  assign bus.dac_b       = b_q;
  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.frame       = frame_q;
  assign bus.mode_active = mode_q;
endmodule

// File: tb/tb_vga_dac_sequencer.sv
// Directed bench for vga_dac_sequencer; vertical timing is shortened (14 lines/frame) to keep runs short.
module tb_vga_dac_sequencer;
  localparam int VV = 8, VF = 2, VS = 2, VB = 2;
  localparam int HT = 800;
  localparam int VT = VV + VF + VS + VB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_dac_sequencer_if bus();

  vga_dac_sequencer #(
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  wire [23:0] rgb = {bus.dac_r, bus.dac_g, bus.dac_b};

  int vectors  = 0;
  int misses   = 0;

  int          bar_h  [9] = '{0, 79, 80, 320, 399, 560, 639, 640, 799};
  logic [23:0] bar_rgb[9] = '{24'h000000, 24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF0000,
                              24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
  logic        bar_de [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(bus.hpos == 10'(h) && bus.vpos == 10'(v)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_%0d_%0d", h, v), 32'(n < 20000), 32'd1);
  endtask

  initial begin
    int hs_first, hs_line0, hs_total, vs_total;
    bit hold_ok;

    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.mode   = 2'd1;
    bus.ext_r  = 8'h00;
    bus.ext_g  = 8'h00;
    bus.ext_b  = 8'h00;

    #12;
    chk("rst_hsync", 32'(bus.hsync), 32'd1);
    chk("rst_vsync", 32'(bus.vsync), 32'd1);
    chk("rst_de",    32'(bus.de), 32'd0);
    chk("rst_dac",   32'(rgb), 32'd0);
    chk("rst_pos",   {12'd0, bus.hpos, bus.vpos}, 32'd0);
    chk("rst_frame", 32'(bus.frame), 32'd0);
    chk("rst_mode",  32'(bus.mode_active), 32'd0);

    // Free-run one frame measuring sync widths and position.
    @(negedge clk);
    rst = 1'b0;
    hs_first = -1; hs_line0 = 0; hs_total = 0; vs_total = 0;
    for (int k = 1; k <= HT * VT; k++) begin
      @(negedge clk);
      if (bus.hsync == 1'b0) begin
        hs_total++;
        if (k <= HT) begin
          hs_line0++;
          if (hs_first < 0) hs_first = k;
        end
      end
      if (bus.vsync == 1'b0) vs_total++;
      if (k == 1) chk("first_pos", {12'd0, bus.hpos, bus.vpos}, 32'd0);
    end
    chk("hsync_start", 32'(hs_first), 32'd657);
    chk("hsync_width", 32'(hs_line0), 32'd96);
    chk("hsync_total", 32'(hs_total), 32'(96 * VT));
    chk("vsync_width", 32'(vs_total), 32'd1600);

    // Frame 1: colour bars on line 0.
    step();
    chk("f1_pos",   {12'd0, bus.hpos, bus.vpos}, 32'd0);
    chk("f1_frame", 32'(bus.frame), 32'd1);
    chk("f1_mode",  32'(bus.mode_active), 32'd1);
    for (int i = 0; i < 9; i++) begin
      goto(bar_h[i], 0);
      chk($sformatf("bars_rgb_%0d", bar_h[i]), 32'(rgb), 32'(bar_rgb[i]));
      chk($sformatf("bars_de_%0d", bar_h[i]), 32'(bus.de), 32'(bar_de[i]));
    end
    bus.mode = 2'd0;
    goto(5, 1);
    chk("midframe_mode_ignored", 32'(bus.mode_active), 32'd1);

    // Frame 2: gradient, then request external mid-frame.
    goto(0, 0);
    chk("f2_frame", 32'(bus.frame), 32'd2);
    chk("f2_mode",  32'(bus.mode_active), 32'd0);
    chk("grad_0_0", 32'(rgb), 32'h000002);
    goto(300, 5);
    chk("grad_300_5", 32'(rgb), 32'h2C0502);
    bus.mode  = 2'd2;
    bus.ext_r = 8'h12;
    bus.ext_g = 8'h34;
    bus.ext_b = 8'h56;
    goto(400, 5);
    chk("grad_400_5", 32'(rgb), 32'h900502);
    chk("grad_mode_held", 32'(bus.mode_active), 32'd0);
    goto(798, VT - 1);
    chk("prewrap_mode",  32'(bus.mode_active), 32'd0);
    chk("prewrap_frame", 32'(bus.frame), 32'd2);
    step();
    chk("wrap_mode",  32'(bus.mode_active), 32'd2);
    chk("wrap_frame", 32'(bus.frame), 32'd3);
    step();
    chk("ext_0_0_pos", {12'd0, bus.hpos, bus.vpos}, 32'd0);
    chk("ext_0_0",     32'(rgb), 32'h123456);
    chk("ext_0_0_de",  32'(bus.de), 32'd1);

    // Freeze at h=10 for 50 cycles while inputs change underneath.
    goto(10, 0);
    chk("pre_hold_rgb", 32'(rgb), 32'h123456);
    bus.enable = 1'b0;
    bus.ext_r  = 8'hAB;
    bus.ext_g  = 8'hCD;
    bus.ext_b  = 8'hEF;
    bus.mode   = 2'd3;
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(bus.hpos == 10'd10 && bus.vpos == 10'd0 && rgb == 24'h123456 &&
            bus.de == 1'b1 && bus.hsync == 1'b1 && bus.frame == 8'd3)) hold_ok = 1'b0;
    end
    chk("hold_50", 32'(hold_ok), 32'd1);
    bus.enable = 1'b1;
    step();
    chk("resume_hpos", 32'(bus.hpos), 32'd11);
    chk("resume_rgb",  32'(rgb), 32'hABCDEF);

    // Frame 4: calibration ramp.
    goto(0, 0);
    chk("f4_mode",  32'(bus.mode_active), 32'd3);
    chk("f4_frame", 32'(bus.frame), 32'd4);
    chk("ramp_v0", 32'(rgb), 32'h000000);
    goto(5, 1);
    chk("ramp_v1", 32'(rgb), 32'h000000);
    goto(5, 2);
    chk("ramp_v2", 32'(rgb), 32'h010101);
    goto(5, 3);
    chk("ramp_v3", 32'(rgb), 32'h010101);
    goto(5, 7);
    chk("ramp_v7", 32'(rgb), 32'h030303);
    goto(5, 8);
    chk("ramp_v8_rgb", 32'(rgb), 32'h000000);
    chk("ramp_v8_de",  32'(bus.de), 32'd0);

    // Asynchronous reset mid-frame.
    goto(400, 6);
    chk("prerst_rgb", 32'(rgb), 32'h030303);
    #2 rst = 1'b1;
    #1;
    chk("arst_pos",   {12'd0, bus.hpos, bus.vpos}, 32'd0);
    chk("arst_frame", 32'(bus.frame), 32'd0);
    chk("arst_mode",  32'(bus.mode_active), 32'd0);
    chk("arst_rgb",   32'(rgb), 32'd0);
    chk("arst_sync",  {30'd0, bus.hsync, bus.vsync}, 32'd3);
    chk("arst_de",    32'(bus.de), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_hpos_%0d", i), 32'(bus.hpos), 32'(i));
    end
    chk("post_rst_vpos",  32'(bus.vpos), 32'd0);
    chk("post_rst_frame", 32'(bus.frame), 32'd0);
    chk("post_rst_rgb",   32'(rgb), 32'h020000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
